pixel_sram_arbiter: RTL and testbench
=====================================

Name: pixel_sram_arbiter

Overview:
- Owns the single external async SRAM holding the 8bpp pixel framebuffer (320x240, 76800 bytes).
- Shares the SRAM between two requesters: the display prefetcher and the CPU pixel-memory port.
  - The display prefetcher streams pixels into the pixel FIFO that feeds the pixel engine.
  - The CPU pixel-memory port does single-byte reads and writes.
- Display has priority whenever the FIFO runs low. A starvation guard bounds CPU latency.
- Restarts the display stream on every vsync, with a FIFO flush.

Parameters:
- FB_WIDTH, 320, pixels per framebuffer line.
- FB_HEIGHT, 240, framebuffer lines.
- LINE_REPEAT, 2, number of times each line is streamed (vertical doubling).
- SRAM_CYCLES, 2, clk cycles per SRAM access (≥1, ≤15).
- CPU_MAX_WAIT, 8, maximum consecutive display accesses allowed while a CPU request is pending.

Ports:
- clk  in  1  system/SRAM clock
- reset_n  in  1  synchronous reset, active-low
- vsync  in  1  active-high vsync, already synchronised into clk
- cpu_req  in  1  CPU request valid; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  17  byte address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  one-cycle pulse; transaction complete
- cpu_rdata  out  8  read data, valid while cpu_ack=1
- fifo_almost_full  in  1  FIFO cannot safely accept more than 1 more byte
- fifo_wr_en  out  1  one-cycle write strobe into the pixel FIFO
- fifo_wr_data  out  8  pixel byte
- fifo_flush  out  1  one-cycle FIFO clear pulse
- sram_addr  out  17  SRAM address
- sram_dq_out  out  8  SRAM write data
- sram_dq_oe  out  1  tristate enable for write data
- sram_dq_in  in  8  SRAM read data
- sram_ce_n  out  1  chip enable
- sram_oe_n  out  1  output enable
- sram_we_n  out  1  write enable

Behaviour:
- Reset outputs, all low except:
  - sram_ce_n = sram_oe_n = sram_we_n = 1.
  - sram_addr = 0.
  - Display counters reset to 0.
  - State = IDLE.
- States:
  - IDLE: access selection happens here.
  - DISP_RD, CPU_RD, CPU_WR: each lasts exactly SRAM_CYCLES cycles, counted by a cycle counter.
  - FLUSH: lasts 1 cycle.
- Selection in IDLE, priority order:
  - (1) vsync rising edge pending → FLUSH.
  - (2) cpu_req and wait_cnt ≥ CPU_MAX_WAIT → CPU op.
  - (3) !fifo_almost_full and frame not finished → DISP_RD.
  - (4) cpu_req → CPU op.
  - (5) otherwise stay in IDLE.
- wait_cnt:
  - Increments on each DISP_RD start while cpu_req=1.
  - Clears on CPU op start.
  - Saturates at CPU_MAX_WAIT.
- Every access returns to IDLE, so there is one idle cycle between accesses. Throughput: 1 access per SRAM_CYCLES+1 cycles.
- Strobe timing during an access:
  - sram_ce_n = 0 for all cycles of the access.
  - Read: sram_oe_n = 0 for all cycles.
  - Write: sram_we_n = 0 for all cycles except the last, during which address and data are held. sram_dq_oe = 1 for the whole write.
- Read data is sampled on the last access cycle.
  - DISP_RD: fifo_wr_en = 1 for one cycle with the sampled byte.
  - CPU_RD: cpu_ack = 1 for one cycle, cpu_rdata = sampled byte.
- CPU_WR: cpu_ack pulses on the last access cycle.
- CPU latency from cpu_req to cpu_ack ≤ (CPU_MAX_WAIT+1)·(SRAM_CYCLES+1)+SRAM_CYCLES+2 cycles, FLUSH excepted.
- cpu_addr ≥ FB_WIDTH·FB_HEIGHT:
  - Write is ignored (no SRAM cycle, ack after 1 cycle).
  - Read returns 0x00 with ack after 1 cycle.
- Display address generation uses x (0..FB_WIDTH-1), rep (0..LINE_REPEAT-1), y (0..FB_HEIGHT-1).
  - Address = y·FB_WIDTH + x, computed incrementally with a line_base register; no multiplier.
  - Counters advance after each DISP_RD.
  - x wraps → rep increments.
  - rep wraps → y increments, line_base += FB_WIDTH.
  - y wraps → frame finished; no further DISP_RD until FLUSH.
- Vsync handling:
  - The vsync rising edge is latched into a pending flag.
  - An access already in progress completes first; its FIFO write is still issued and is then discarded by the flush.
  - FLUSH: fifo_flush = 1, counters and line_base cleared, frame-finished cleared, pending flag cleared.
  - A CPU request pending during FLUSH is served afterwards per the normal priority; wait_cnt is kept.
- Simultaneous vsync edge and access start: the access starts and the flush follows it.
- Reset mid-access: strobes deassert on the next edge; no ack is issued.

Decomposition:
- Shared package (gpu_pkg):
  - State encoding.
  - FB_WIDTH, FB_HEIGHT, FB_SIZE = 76800.
  - SRAM address width 17.
- One sub-module: pixel_display_addr_gen (x/rep/y counters, line_base, frame_done, advance/clear inputs).
- FSM, strobe generation and CPU port stay in the top module.

Test Plan:
- CPU write then read, SRAM_CYCLES=2, FIFO kept almost-full:
  - cpu write 0x00123 ← 0xA5 → sram_we_n low for 1 cycle, ack.
  - Read of 0x00123 → cpu_rdata = 0xA5, ack 3 cycles after the request is accepted.
- Display stream with an SRAM model filled as byte = addr[7:0], FIFO never full, after vsync:
  - First 640 fifo writes = 0..319, 0..319 (addresses repeat for line doubling).
  - Next write has address 320.
- Starvation guard, fifo_almost_full held 0 and cpu_req asserted continuously:
  - A CPU access occurs after exactly 8 DISP_RDs.
  - Pattern repeats 8:1.
- Vsync mid-line, at the 100th byte of line 5:
  - In-flight read completes, then fifo_flush pulses.
  - Next DISP_RD address = 0.
- Frame end:
  - After 153600 DISP_RDs, no further fifo_wr_en until a vsync edge.
  - CPU requests are still served with ack.
- Boundary and reset:
  - cpu read at 76800 → rdata 0x00, no SRAM strobe.
  - reset_n low during CPU_WR → strobes high next cycle, no ack.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared constants and state encoding for the pixel framebuffer SRAM path.
package gpu_pkg;

    localparam int unsigned SRAM_AW   = 17;
    localparam int unsigned FB_WIDTH  = 320;
    localparam int unsigned FB_HEIGHT = 240;
    localparam int unsigned FB_SIZE   = FB_WIDTH * FB_HEIGHT;

    typedef enum logic [2:0] {
        StIdle,
        StDispRd,
        StCpuRd,
        StCpuWr,
        StFlush
    } arb_state_e;

    // True while the SRAM is being driven by an access.
    function automatic logic is_access(arb_state_e s);
        return s inside {StDispRd, StCpuRd, StCpuWr};
    endfunction

endpackage

// File: rtl/pixel_display_addr_gen.sv
// Raster address generator for the display stream: walks x, then line repeat, then y.
// Address is line_base + x so no multiplier is needed.
module pixel_display_addr_gen
    import gpu_pkg::*;
#(
    parameter int unsigned FbWidth    = FB_WIDTH,
    parameter int unsigned FbHeight   = FB_HEIGHT,
    parameter int unsigned LineRepeat = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               advance,
    input  logic               clear,
    output logic [SRAM_AW-1:0] addr,
    output logic               frame_done
);

    localparam int unsigned XW = (FbWidth > 1) ? $clog2(FbWidth) : 1;
    localparam int unsigned RW = (LineRepeat > 1) ? $clog2(LineRepeat) : 1;
    localparam int unsigned YW = (FbHeight > 1) ? $clog2(FbHeight) : 1;

    logic [XW-1:0]      x_q;
    logic [RW-1:0]      rep_q;
    logic [YW-1:0]      y_q;
    logic [SRAM_AW-1:0] base_q;
    logic               done_q;

    // Counter chain; once the last line is streamed it parks until cleared.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            x_q    <= '0;
            rep_q  <= '0;
            y_q    <= '0;
            base_q <= '0;
            done_q <= 1'b0;
        end else if (advance && !done_q) begin
            if (x_q == XW'(FbWidth - 1)) begin
                x_q <= '0;
                if (rep_q == RW'(LineRepeat - 1)) begin
                    rep_q <= '0;
                    if (y_q == YW'(FbHeight - 1)) begin
                        y_q    <= '0;
                        base_q <= '0;
                        done_q <= 1'b1;
                    end else begin
                        y_q    <= y_q + 1'b1;
                        base_q <= base_q + SRAM_AW'(FbWidth);
                    end
                end else begin
                    rep_q <= rep_q + 1'b1;
                end
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    assign addr       = base_q + SRAM_AW'(x_q);
    assign frame_done = done_q;

endmodule

// File: rtl/pixel_sram_arbiter.sv
// Arbitrates the framebuffer SRAM between the display prefetcher and the CPU byte port.
// Every access returns through IDLE, where the next access is chosen.
module pixel_sram_arbiter
    import gpu_pkg::*;
#(
    parameter int unsigned FbWidth    = FB_WIDTH,
    parameter int unsigned FbHeight   = FB_HEIGHT,
    parameter int unsigned LineRepeat = 2,
    parameter int unsigned SramCycles = 2,
    parameter int unsigned CpuMaxWait = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                vsync,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [SRAM_AW-1:0]  cpu_addr,
    input  logic [7:0]          cpu_wdata,
    output logic                cpu_ack,
    output logic [7:0]          cpu_rdata,
    input  logic                fifo_almost_full,
    output logic                fifo_wr_en,
    output logic [7:0]          fifo_wr_data,
    output logic                fifo_flush,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [7:0]          sram_dq_out,
    output logic                sram_dq_oe,
    input  logic [7:0]          sram_dq_in,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n
);

    localparam logic [SRAM_AW-1:0] FbSize  = SRAM_AW'(FbWidth * FbHeight);
    localparam logic [3:0]         LastCyc = 4'(SramCycles - 1);
    localparam int unsigned        WaitW   = $clog2(CpuMaxWait + 1);
    localparam logic [WaitW-1:0]   WaitMax = WaitW'(CpuMaxWait);

    arb_state_e         state_q, state_d;
    logic [3:0]         cyc_q, cyc_d;
    logic [WaitW-1:0]   wait_q, wait_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [7:0]         dq_q, dq_d, rdata_q, rdata_d, wr_data_q, wr_data_d;
    logic               ack_q, ack_d, wr_en_q, wr_en_d;
    logic               vsync_q, pend_q;
    logic               advance, cpu_start, cpu_go, last, frame_done;
    logic [SRAM_AW-1:0] disp_addr;

    pixel_display_addr_gen #(
        .FbWidth    (FbWidth),
        .FbHeight   (FbHeight),
        .LineRepeat (LineRepeat)
    ) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .advance    (advance),
        .clear      (state_q == StFlush),
        .addr       (disp_addr),
        .frame_done (frame_done)
    );

    // A request whose ack is already on the bus must not be selected again.
    assign cpu_go = cpu_req && !ack_q;
    assign last   = (cyc_q == LastCyc);

    // Next-state, access selection and read-data capture.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        wait_d    = wait_q;
        addr_d    = addr_q;
        dq_d      = dq_q;
        ack_d     = 1'b0;
        rdata_d   = rdata_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        advance   = 1'b0;
        cpu_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                cyc_d = '0;
                if (pend_q) begin
                    state_d = StFlush;
                end else if (cpu_go && wait_q >= WaitMax) begin
                    cpu_start = 1'b1;
                end else if (!fifo_almost_full && !frame_done) begin
                    state_d = StDispRd;
                    addr_d  = disp_addr;
                    advance = 1'b1;
                    if (cpu_go && wait_q < WaitMax) wait_d = wait_q + 1'b1;
                end else if (cpu_go) begin
                    cpu_start = 1'b1;
                end
            end
            StDispRd, StCpuRd, StCpuWr: begin
                if (last) begin
                    state_d = StIdle;
                    cyc_d   = '0;
                    if (state_q == StDispRd) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = sram_dq_in;
                    end else if (state_q == StCpuRd) begin
                        ack_d   = 1'b1;
                        rdata_d = sram_dq_in;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                    // Write ack is registered so it lands on the final access cycle.
                    if (state_q == StCpuWr && cyc_d == LastCyc) ack_d = 1'b1;
                end
            end
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (cpu_start) begin
            wait_d = '0;
            if (cpu_addr >= FbSize) begin
                // Outside the framebuffer: no SRAM cycle, reads return zero.
                ack_d = 1'b1;
                if (!cpu_we) rdata_d = 8'h00;
            end else begin
                state_d = cpu_we ? StCpuWr : StCpuRd;
                addr_d  = cpu_addr;
                if (cpu_we) dq_d = cpu_wdata;
                ack_d   = cpu_we && (LastCyc == 4'd0);
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cyc_q     <= '0;
            wait_q    <= '0;
            addr_q    <= '0;
            dq_q      <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            wait_q    <= wait_d;
            addr_q    <= addr_d;
            dq_q      <= dq_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Vsync edge latch; an edge arriving during FLUSH survives into the next frame.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vsync_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            vsync_q <= vsync;
            pend_q  <= (pend_q && state_q != StFlush) || (vsync && !vsync_q);
        end
    end

    assign sram_ce_n    = !is_access(state_q);
    assign sram_oe_n    = !(state_q == StDispRd || state_q == StCpuRd);
    assign sram_we_n    = !(state_q == StCpuWr && !last);
    assign sram_dq_oe   = (state_q == StCpuWr);
    assign sram_addr    = addr_q;
    assign sram_dq_out  = dq_q;
    assign fifo_flush   = (state_q == StFlush);
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = wr_data_q;
    assign cpu_ack      = ack_q;
    assign cpu_rdata    = rdata_q;

endmodule

// File: tb/tb_pixel_sram_arbiter.sv
// Directed bench: full-size arbiter for CPU/display/vsync behaviour, plus a tiny
// 4x3 framebuffer instance so the end-of-frame case fits in a short run.
module tb_pixel_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0, vsync = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [16:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        fifo_almost_full = 1'b1;
    logic        cpu_ack, fifo_wr_en, fifo_flush, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [7:0]  cpu_rdata, fifo_wr_data, sram_dq_out, sram_dq_in;
    logic [16:0] sram_addr;

    pixel_sram_arbiter u_dut (
        .clk(clk), .reset_n(reset_n), .vsync(vsync), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .fifo_almost_full(fifo_almost_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .fifo_flush(fifo_flush), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    // Small instance
    logic        s_vsync = 1'b0, s_cpu_req = 1'b0;
    logic [16:0] s_cpu_addr = 17'd5;
    logic        s_cpu_ack, s_wr_en, s_flush, s_dq_oe, s_ce_n, s_oe_n, s_we_n;
    logic [7:0]  s_rdata, s_wr_data, s_dq_out, s_dq_in;
    logic [16:0] s_addr;

    pixel_sram_arbiter #(.FbWidth(4), .FbHeight(3), .LineRepeat(2)) u_small (
        .clk(clk), .reset_n(reset_n), .vsync(s_vsync), .cpu_req(s_cpu_req), .cpu_we(1'b0),
        .cpu_addr(s_cpu_addr), .cpu_wdata(8'h00), .cpu_ack(s_cpu_ack), .cpu_rdata(s_rdata),
        .fifo_almost_full(1'b0), .fifo_wr_en(s_wr_en), .fifo_wr_data(s_wr_data),
        .fifo_flush(s_flush), .sram_addr(s_addr), .sram_dq_out(s_dq_out),
        .sram_dq_oe(s_dq_oe), .sram_dq_in(s_dq_in), .sram_ce_n(s_ce_n), .sram_oe_n(s_oe_n),
        .sram_we_n(s_we_n)
    );

    // SRAM models: main memory starts as byte = addr[7:0]; small one is addr-derived.
    logic [7:0] mem [0:76799];
    logic       mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 76800; i++) mem[i] <= i[7:0];
            mem_init <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_addr < 17'd76800) begin
            mem[sram_addr] <= sram_dq_out;
        end
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n && sram_addr < 17'd76800) ?
                        mem[sram_addr] : 8'h00;
    assign s_dq_in    = (!s_ce_n && !s_oe_n) ? s_addr[7:0] : 8'h00;

    // Event monitors
    int          n_wr = 0, n_flush = 0, n_ack = 0, n_ce = 0, n_we = 0;
    logic [7:0]  dq[$];
    logic [16:0] aq[$];
    int          s_nwr = 0, s_nflush = 0;
    logic [16:0] s_last_addr = '0, s_first_addr = 17'h1ffff;
    logic [7:0]  s_last_data = '0;
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            dq.push_back(fifo_wr_data);
            aq.push_back(sram_addr);
            n_wr++;
        end
        if (fifo_flush) n_flush++;
        if (cpu_ack) n_ack++;
        if (!sram_ce_n) n_ce++;
        if (!sram_we_n) n_we++;
        if (!reset_n || s_flush) begin
            s_nwr = 0;
            if (s_flush) s_nflush++;
        end else if (s_wr_en) begin
            if (s_nwr == 0) s_first_addr = s_addr;
            s_last_addr = s_addr;
            s_last_data = s_wr_data;
            s_nwr++;
        end
    end

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // lat = cycle of ack counted from the cycle the request is first presented (0).
    task automatic cpu_op(input logic we, input logic [16:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output int lat);
        logic done;
        @(posedge clk); #1;
        cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
        done = 1'b0; lat = -1; rd = 8'h00;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                done = 1'b1; lat = i; rd = cpu_rdata;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(posedge clk); #1 vsync = 1'b1;
        @(posedge clk); #1 vsync = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int lat, ce0, we0, f0, a0, bad, wr_idx, fl_idx, n_before, post_addr, post_data;
        int gaps[4];
        int nacks, cnt;
        logic found, prev_ce;
        logic [16:0] wr_addr;

        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_ce_n", sram_ce_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_we_n", sram_we_n, 1);
        check("rst_addr", sram_addr, 0);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_fifo_wr", fifo_wr_en, 0);
        check("rst_flush", fifo_flush, 0);
        check("rst_ack", cpu_ack, 0);

        // CPU write/read with display held off
        we0 = n_we;
        cpu_op(1'b1, 17'h00123, 8'hA5, rd, lat);
        check("wr_lat", lat, 2);
        check("wr_we_cycles", n_we - we0, 1);
        cpu_op(1'b0, 17'h00123, 8'h00, rd, lat);
        check("rd_data", rd, 8'hA5);
        check("rd_lat", lat, 3);
        cpu_op(1'b1, 17'h00123, 8'h23, rd, lat);
        check("restore_lat", lat, 2);

        // Out-of-range CPU accesses
        ce0 = n_ce;
        cpu_op(1'b0, 17'd76800, 8'h00, rd, lat);
        check("oor_rd_data", rd, 8'h00);
        check("oor_rd_lat", lat, 1);
        check("oor_rd_strobe", n_ce - ce0, 0);
        ce0 = n_ce;
        cpu_op(1'b1, 17'd76801, 8'hFF, rd, lat);
        check("oor_wr_lat", lat, 1);
        check("oor_wr_strobe", n_ce - ce0, 0);

        // Display stream after vsync
        f0 = n_flush;
        pulse_vsync();
        repeat (4) @(posedge clk);
        check("vs_flush", n_flush - f0, 1);
        dq.delete(); aq.delete();
        #1 fifo_almost_full = 1'b0;
        for (int i = 0; i < 3000 && dq.size() < 641; i++) @(negedge clk);
        fifo_almost_full = 1'b1;
        check("disp_count", 32'(dq.size() >= 641), 1);
        bad = 0;
        for (int i = 0; i < 640; i++) if (dq[i] !== 8'(i % 320)) bad++;
        check("disp_line_data", bad, 0);
        check("disp_addr_319", aq[319], 319);
        check("disp_addr_repeat", aq[320], 0);
        check("disp_addr_640", aq[640], 320);
        check("disp_data_640", dq[640], 8'd64);

        // Vsync at the 100th byte of line 5 (first pass)
        repeat (6) @(posedge clk);
        pulse_vsync();
        repeat (4) @(posedge clk);
        #1 fifo_almost_full = 1'b0;
        found = 1'b0; prev_ce = 1'b1;
        for (int i = 0; i < 12000 && !found; i++) begin
            @(negedge clk);
            if (!sram_ce_n && prev_ce && sram_addr == 17'd1699) found = 1'b1;
            prev_ce = sram_ce_n;
        end
        check("mid_found", found, 1);
        vsync = 1'b1;
        wr_idx = -1; fl_idx = -1; n_before = 0; wr_addr = '0; post_addr = -1; post_data = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) vsync = 1'b0;
            if (fifo_wr_en && fl_idx < 0) begin
                if (wr_idx < 0) begin
                    wr_idx = i; wr_addr = sram_addr;
                end
                n_before++;
            end else if (fifo_wr_en && post_addr < 0) begin
                post_addr = int'(sram_addr); post_data = int'(fifo_wr_data);
            end
            if (fifo_flush && fl_idx < 0) fl_idx = i;
        end
        check("mid_inflight_addr", wr_addr, 1699);
        check("mid_inflight_idx", wr_idx, 1);
        check("mid_writes_before_flush", n_before, 1);
        check("mid_flush_idx", fl_idx, 2);
        check("mid_restart_addr", post_addr, 0);
        check("mid_restart_data", post_data, 0);

        // Starvation guard: continuous CPU writes against a hungry display
        cpu_we = 1'b1; cpu_addr = 17'h01000; cpu_wdata = 8'h00;
        @(posedge clk); #1 cpu_req = 1'b1;
        nacks = 0; cnt = 0;
        for (int i = 0; i < 400 && nacks < 4; i++) begin
            @(negedge clk);
            if (fifo_wr_en) cnt++;
            if (cpu_ack) begin
                gaps[nacks] = cnt; nacks++; cnt = 0;
            end
        end
        cpu_req = 1'b0;
        fifo_almost_full = 1'b1;
        check("starve_acks", nacks, 4);
        check("starve_gap1", gaps[1], 8);
        check("starve_gap2", gaps[2], 8);
        check("starve_gap3", gaps[3], 8);

        // Reset in the middle of a CPU write
        repeat (6) @(posedge clk);
        a0 = n_ack;
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = 17'h00200; cpu_wdata = 8'h77; cpu_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (!sram_we_n) found = 1'b1;
        end
        check("rst_wr_started", found, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_ce_n", sram_ce_n, 1);
        check("rstmid_we_n", sram_we_n, 1);
        check("rstmid_dq_oe", sram_dq_oe, 0);
        @(negedge clk);
        check("rstmid_no_ack", n_ack - a0, 0);
        cpu_req = 1'b0;
        reset_n = 1'b1;

        // Frame end on the 4x3, line-doubled instance: 24 reads then silence
        repeat (150) @(posedge clk);
        check("small_frame_count", s_nwr, 24);
        check("small_last_addr", s_last_addr, 11);
        check("small_last_data", s_last_data, 11);
        #1 s_cpu_req = 1'b1;
        found = 1'b0; rd = 8'h00;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (s_cpu_ack) begin
                found = 1'b1; rd = s_rdata;
            end
        end
        @(posedge clk); #1 s_cpu_req = 1'b0;
        check("small_cpu_ack", found, 1);
        check("small_cpu_rdata", rd, 8'd5);
        repeat (20) @(posedge clk);
        check("small_no_more_disp", s_nwr, 24);
        #1 s_vsync = 1'b1;
        @(posedge clk); #1 s_vsync = 1'b0;
        repeat (40) @(posedge clk);
        check("small_flush", s_nflush, 1);
        check("small_restart", 32'(s_nwr >= 6), 1);
        check("small_restart_addr", s_first_addr, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
